// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: CP0 exception codes, controller FSM states and the default exception vector
package exc_ctrl_pkg;
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
   typedef enum logic [1:0] {IDLE, TAKE, DRAIN} state_t;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: fixed-priority encoder, lowest set index wins
module exc_prio_enc #(
   parameter int NUM_SRC = 4,
   localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] req,
   output logic               any,
   output logic [IW-1:0]      idx,
   output logic [NUM_SRC-1:0] grant
);
   always_comb begin
      idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (req[i]) idx = IW'(i);
   end
   assign any   = |req;
   assign grant = req & ~(req - NUM_SRC'(1));
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-stage exception/interrupt arbiter producing flush, redirect and CP0 strobes
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ADDR_W = 32,
   parameter int HW_INT = 6,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inst_valid,
   input  logic [ADDR_W-1:0]    inst_pc,
   input  logic                 inst_bd,
   input  logic [NUM_SRC-1:0]   exc_req,
   input  logic [5*NUM_SRC-1:0] exc_code,
   input  logic [NUM_SRC-1:0]   exc_badv_src,
   input  logic [ADDR_W-1:0]    exc_badvaddr,
   input  logic                 eret,
   input  logic [HW_INT-1:0]    hw_int,
   input  logic [1:0]           sw_int,
   input  logic                 status_ie,
   input  logic                 status_exl,
   input  logic [7:0]           status_im,
   input  logic [ADDR_W-1:0]    cp0_epc,
   output logic                 flush,
   output logic [ADDR_W-1:0]    redirect_pc,
   output logic                 cp0_exc_we,
   output logic [4:0]           cp0_exccode,
   output logic                 cp0_bd,
   output logic                 cp0_epc_we,
   output logic [ADDR_W-1:0]    cp0_epc_wdata,
   output logic                 cp0_badv_we,
   output logic [ADDR_W-1:0]    cp0_badv_wdata,
   output logic                 exl_clr,
   output logic [7:0]           int_pending,
   output logic                 busy
);
   localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
   localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
   state_t state;
   logic [CW-1:0] cnt;
   logic [HW_INT-1:0] hw_int_q;
   logic [7:0] ip;
   logic any, int_take, exc_take, eret_take, trap, eval;
   logic [IW-1:0] win;
   logic [NUM_SRC-1:0] grant;
   logic [ADDR_W-1:0] epc;
   exc_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (.req(exc_req), .any(any), .idx(win), .grant(grant));
   assign ip        = 8'({hw_int_q, sw_int});
   assign int_take  = inst_valid & status_ie & ~status_exl & |(ip & status_im);
   assign exc_take  = inst_valid & any;
   assign eret_take = inst_valid & eret;
   assign trap      = int_take | exc_take;
   assign epc       = inst_bd ? inst_pc - ADDR_W'(4) : inst_pc;
   // the last drain cycle already samples events so the next flush follows without a gap
   assign eval      = state == IDLE || (state == DRAIN && cnt == '0);
   assign busy      = state != IDLE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         hw_int_q       <= '0;
         int_pending    <= '0;
         flush          <= 1'b0;
         redirect_pc    <= '0;
         cp0_exc_we     <= 1'b0;
         cp0_exccode    <= '0;
         cp0_bd         <= 1'b0;
         cp0_epc_we     <= 1'b0;
         cp0_epc_wdata  <= '0;
         cp0_badv_we    <= 1'b0;
         cp0_badv_wdata <= '0;
         exl_clr        <= 1'b0;
      end else begin
         hw_int_q       <= hw_int;
         int_pending    <= ip;
         flush          <= 1'b0;
         redirect_pc    <= '0;
         cp0_exc_we     <= 1'b0;
         cp0_exccode    <= '0;
         cp0_bd         <= 1'b0;
         cp0_epc_we     <= 1'b0;
         cp0_epc_wdata  <= '0;
         cp0_badv_we    <= 1'b0;
         cp0_badv_wdata <= '0;
         exl_clr        <= 1'b0;
         if (eval && (trap || eret_take)) begin
            state          <= TAKE;
            flush          <= 1'b1;
            redirect_pc    <= trap ? EXC_VECTOR : cp0_epc;
            cp0_exc_we     <= trap;
            cp0_exccode    <= int_take ? EXC_INT : exc_take ? exc_code[5*win +: 5] : 5'h00;
            cp0_bd         <= trap & inst_bd & ~status_exl;
            cp0_epc_we     <= trap & ~status_exl;
            cp0_epc_wdata  <= trap ? epc : '0;
            cp0_badv_we    <= ~int_take & exc_take & |(exc_badv_src & grant);
            cp0_badv_wdata <= ~int_take & exc_take ? exc_badvaddr : '0;
            exl_clr        <= ~trap;
         end else if (state == TAKE) begin
            state <= DRAIN_CYCLES > 0 ? DRAIN : IDLE;
            cnt   <= CW'(DRAIN_CYCLES > 0 ? DRAIN_CYCLES - 1 : 0);
         end else if (state == DRAIN) begin
            state <= cnt == '0 ? IDLE : DRAIN;
            cnt   <= cnt == '0 ? '0 : cnt - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: randomized + directed scoreboard bench for exc_ctrl against a cycle-level reference model
module tb_exc_ctrl;
   localparam int NS = 4;
   localparam int D = 2;
   localparam logic [31:0] VEC = 32'hBFC0_0380;
   typedef struct {
      int cyc; logic [31:0] redirect; logic [4:0] code; logic exc_we, bd, epc_we;
      logic [31:0] epc; logic badv_we; logic [31:0] badv; logic exl_clr;
   } frec_t;
   typedef struct {int cyc; logic busy; logic [7:0] pend; logic rst;} crec_t;
   logic clk = 1'b1;
   logic rst_n, inst_valid, inst_bd, eret, status_ie, status_exl;
   logic [31:0] inst_pc, exc_badvaddr, cp0_epc;
   logic [NS-1:0] exc_req, exc_badv_src;
   logic [5*NS-1:0] exc_code;
   logic [5:0] hw_int;
   logic [1:0] sw_int;
   logic [7:0] status_im;
   logic flush, cp0_exc_we, cp0_bd, cp0_epc_we, cp0_badv_we, exl_clr, busy;
   logic [31:0] redirect_pc, cp0_epc_wdata, cp0_badv_wdata;
   logic [4:0] cp0_exccode;
   logic [7:0] int_pending;
   frec_t fq[$];
   crec_t cq[$];
   int cyc = 0, cmp = 0, bad = 0;
   int next_free = 0, busy_until = -1;
   logic [5:0] hwq = '0;
   always #5 clk = ~clk;
   exc_ctrl #(.DRAIN_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_bd(inst_bd),
      .exc_req(exc_req), .exc_code(exc_code), .exc_badv_src(exc_badv_src), .exc_badvaddr(exc_badvaddr),
      .eret(eret), .hw_int(hw_int), .sw_int(sw_int), .status_ie(status_ie), .status_exl(status_exl),
      .status_im(status_im), .cp0_epc(cp0_epc), .flush(flush), .redirect_pc(redirect_pc),
      .cp0_exc_we(cp0_exc_we), .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd), .cp0_epc_we(cp0_epc_we),
      .cp0_epc_wdata(cp0_epc_wdata), .cp0_badv_we(cp0_badv_we), .cp0_badv_wdata(cp0_badv_wdata),
      .exl_clr(exl_clr), .int_pending(int_pending), .busy(busy)
   );
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      cmp++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
      end
   endtask
   // Reference: events seen at the end of cycle c flush in c+1; the controller is deaf
   // until the end of its last drain cycle (or one extra cycle when there is no drain).
   task automatic model();
      int c, w;
      logic it, et;
      logic [7:0] ip;
      frec_t r;
      crec_t k;
      c = cyc;
      ip = {hwq, sw_int};
      k.cyc = c + 1;
      k.rst = !rst_n;
      if (!rst_n) begin
         next_free = c + 1;
         busy_until = c;
         k.pend = '0;
         hwq = '0;
      end else begin
         k.pend = ip;
         if (c >= next_free && inst_valid) begin
            it = status_ie && !status_exl && (ip & status_im) != 0;
            et = exc_req != 0;
            if (it || et || eret) begin
               w = 0;
               for (int i = NS - 1; i >= 0; i--) if (exc_req[i]) w = i;
               r.cyc = c + 1;
               r.redirect = (it || et) ? VEC : cp0_epc;
               r.code = it ? 5'h00 : et ? exc_code[5*w +: 5] : 5'h00;
               r.exc_we = it || et;
               r.bd = (it || et) && inst_bd && !status_exl;
               r.epc_we = (it || et) && !status_exl;
               r.epc = inst_bd ? inst_pc - 32'd4 : inst_pc;
               r.badv_we = !it && et && exc_badv_src[w];
               r.badv = exc_badvaddr;
               r.exl_clr = !(it || et);
               fq.push_back(r);
               next_free = c + 1 + (D > 0 ? D : 1);
               busy_until = c + 1 + D;
            end
         end
         hwq = hw_int;
      end
      k.busy = (c + 1) <= busy_until;
      cq.push_back(k);
   endtask
   task automatic cycle();
      model();
      @(posedge clk);
      #1 cyc++;
   endtask
   task automatic defaults();
      inst_valid = 0; inst_bd = 0; eret = 0; status_ie = 0; status_exl = 0;
      inst_pc = '0; exc_badvaddr = '0; cp0_epc = '0; exc_req = '0; exc_badv_src = '0;
      exc_code = '0; hw_int = '0; sw_int = '0; status_im = '0;
   endtask
   initial begin
      frec_t r;
      crec_t k;
      forever begin
         @(negedge clk);
         if (flush) begin
            if (fq.size() == 0 || fq[0].cyc != cyc) begin
               cmp++; bad++;
               $display("FAIL unexpected_flush: got flush=1 want flush=0 (cycle %0d)", cyc);
            end else begin
               r = fq.pop_front();
               chk("redirect_pc", redirect_pc, r.redirect);
               chk("exccode", 32'(cp0_exccode), 32'(r.code));
               chk("exc_we", 32'(cp0_exc_we), 32'(r.exc_we));
               chk("bd", 32'(cp0_bd), 32'(r.bd));
               chk("epc_we", 32'(cp0_epc_we), 32'(r.epc_we));
               if (r.epc_we) chk("epc_wdata", cp0_epc_wdata, r.epc);
               chk("badv_we", 32'(cp0_badv_we), 32'(r.badv_we));
               if (r.badv_we) chk("badv_wdata", cp0_badv_wdata, r.badv);
               chk("exl_clr", 32'(exl_clr), 32'(r.exl_clr));
            end
         end else begin
            chk("idle_strobes", 32'({cp0_exc_we, cp0_epc_we, cp0_badv_we, exl_clr}), 32'd0);
            if (fq.size() != 0 && fq[0].cyc <= cyc) begin
               r = fq.pop_front();
               cmp++; bad++;
               $display("FAIL missed_flush: got flush=0 want flush=1 (cycle %0d)", cyc);
            end
         end
         while (cq.size() != 0 && cq[0].cyc <= cyc) begin
            k = cq.pop_front();
            if (k.cyc == cyc) begin
               chk("busy", 32'(busy), 32'(k.busy));
               chk("int_pending", 32'(int_pending), 32'(k.pend));
               if (k.rst) begin
                  chk("rst_flush", 32'(flush), 32'd0);
                  chk("rst_redirect", redirect_pc, 32'd0);
                  chk("rst_fields", 32'({cp0_exccode, cp0_bd}), 32'd0);
                  chk("rst_wdata", cp0_epc_wdata | cp0_badv_wdata, 32'd0);
               end
            end
         end
      end
   end
   initial begin
      defaults();
      rst_n = 0;
      repeat (2) cycle();
      rst_n = 1;
      cycle();
      inst_valid = 1; exc_req = 4'b0100; exc_code[14:10] = 5'h08; inst_pc = 32'hBFC0_0100;
      cycle();
      defaults(); repeat (4) cycle();
      inst_valid = 1; exc_req = 4'b1010; exc_code[9:5] = 5'h04; exc_code[19:15] = 5'h0C;
      inst_bd = 1; inst_pc = 32'h8000_0010; exc_badv_src = 4'b0010; exc_badvaddr = 32'h1234_5678;
      cycle();
      defaults(); repeat (4) cycle();
      hw_int = 6'b000001; status_im = 8'h04; status_ie = 1;
      cycle();
      inst_valid = 1; exc_req = 4'b0001; exc_code[4:0] = 5'h0C; inst_pc = 32'h8000_0200;
      cycle();
      defaults(); repeat (4) cycle();
      inst_valid = 1; exc_req = 4'b0001; exc_code[4:0] = 5'h0A; inst_pc = 32'h8000_0100;
      repeat (5) cycle();
      defaults(); repeat (4) cycle();
      inst_valid = 1; eret = 1; cp0_epc = 32'h8000_2000;
      cycle();
      defaults(); repeat (3) cycle();
      inst_valid = 1; status_exl = 1; exc_req = 4'b0100; exc_code[14:10] = 5'h08;
      inst_pc = 32'h8000_0040; inst_bd = 1;
      cycle();
      defaults(); repeat (3) cycle();
      inst_valid = 1; inst_pc = 32'h0000_0000; inst_bd = 1; exc_req = 4'b0001; exc_code[4:0] = 5'h05;
      cycle();
      defaults(); cycle();
      rst_n = 0; cycle();
      rst_n = 1; inst_valid = 1; exc_req = 4'b0010; exc_code[9:5] = 5'h09; inst_pc = 32'h8000_0300;
      cycle();
      defaults(); repeat (4) cycle();
      repeat (3000) begin
         rst_n = ($urandom % 64) != 0;
         inst_valid = ($urandom % 4) != 0;
         inst_pc = $urandom;
         inst_bd = 1'($urandom);
         exc_req = ($urandom % 3 == 0) ? NS'($urandom) : '0;
         exc_code = 20'($urandom);
         exc_badv_src = NS'($urandom);
         exc_badvaddr = $urandom;
         eret = ($urandom % 6) == 0;
         if ($urandom % 8 == 0) hw_int = 6'($urandom);
         sw_int = ($urandom % 10 == 0) ? 2'($urandom) : 2'b00;
         status_ie = 1'($urandom);
         status_exl = ($urandom % 4) == 0;
         status_im = 8'($urandom);
         cp0_epc = $urandom;
         cycle();
      end
      defaults(); rst_n = 1;
      repeat (6) cycle();
      @(negedge clk); #1;
      chk("flush_queue_empty", 32'(fq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
